// File: rtl/if_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : if_prefetch_unit_pkg
// Brief  : Shared RISC-V fetch types and constants used by the prefetch unit.
// Rev    : 1.0 - initial release
// ============================================================================
package if_prefetch_unit_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // Major opcodes of the supported RV32I subset
  localparam logic [6:0] OPC_LW    = 7'b000_0011;
  localparam logic [6:0] OPC_SW    = 7'b010_0011;
  localparam logic [6:0] OPC_BEQ   = 7'b110_0011;
  localparam logic [6:0] OPC_ARITH = 7'b011_0011;
  localparam logic [6:0] OPC_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_LUI   = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC = 7'b001_0111;
  localparam logic [6:0] OPC_JAL   = 7'b110_1111;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // One buffered fetch result: the word and the address it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_unit_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : if_prefetch_unit_sync_fifo
// Brief  : Synchronous FIFO with push/pop/clear and occupancy status.
//          Head data is read combinationally from the storage array.
// Rev    : 1.0 - initial release
// ============================================================================
module if_prefetch_unit_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear behaves like a local reset
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push && !clear && !rst) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module : if_prefetch_unit
// Brief  : Instruction prefetch stage. Issues word fetches on a req/gnt +
//          rvalid bus under a credit limit, buffers returned words with their
//          PCs and hands them to decode over valid/ready. A redirect flushes
//          the buffer and discards every response still in flight.
// Rev    : 1.0 - initial release
// ============================================================================
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CREDITS   = (CW + 1)'(DEPTH);

  logic              rst_q;
  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop_cnt;

  logic              grant;
  logic              credit_ok;
  logic              resp_drop;
  logic              instr_push;
  logic              instr_pop;

  logic [XLEN-1:0]   tag_pc;
  logic [CW-1:0]     tag_count;
  logic              tag_full;
  logic              tag_empty;

  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;
  logic [CW-1:0]     instr_count;
  logic              instr_full;
  logic              instr_empty;

  // Every buffered or in-flight word holds one credit, so the buffer can
  // always absorb every response that is still on its way back.
  assign credit_ok = ({1'b0, instr_count} + {1'b0, outstanding}) < CREDITS;

  // Request depends only on registered state plus the reset/redirect inputs.
  assign imem_req  = !rst && !rst_q && !redirect_valid && credit_ok;
  assign imem_addr = rst ? RESET_PC : fetch_pc;
  assign grant     = imem_req && imem_gnt;

  assign outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid);

  // Stale responses are swallowed while drop_cnt is non-zero; a redirect
  // cycle also swallows whatever arrives with it.
  assign resp_drop  = imem_rvalid && (drop_cnt != '0);
  assign instr_push = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign instr_pop  = instr_valid && instr_ready && !redirect_valid;

  assign push_entry = '{pc: tag_pc, instr: imem_rdata};

  assign instr_valid = !rst && !instr_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  // Delayed reset keeps the request low for one cycle after reset release
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Fetch PC: reset, then redirect, then advance one word per grant (wraps)
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align4(redirect_pc);
    end else if (grant) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // In-flight count and number of in-flight words that must be discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      // outstanding already includes words pending a drop, so after a
      // redirect every word still in flight at the end of this cycle is stale.
      if (redirect_valid) begin
        drop_cnt <= outstanding_nxt;
      end else if (resp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // PC of each granted request, matched in order against the responses
  if_prefetch_unit_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (fetch_pc),
    .pop       (imem_rvalid),
    .clear     (1'b0),
    .head_data (tag_pc),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Returned words waiting for decode
  if_prefetch_unit_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (instr_push),
    .push_data (push_entry),
    .pop       (instr_pop),
    .clear     (redirect_valid),
    .head_data (head_entry),
    .count     (instr_count),
    .full      (instr_full),
    .empty     (instr_empty)
  );

  // Bus and buffer sanity: no orphan responses, no queue overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && (outstanding == '0)));
      assert (!(imem_rvalid && tag_empty));
      assert (!(grant && tag_full && !imem_rvalid));
      assert (!(instr_push && instr_full && !instr_pop));
      assert (tag_count == outstanding);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_if_prefetch_unit
// Brief  : Directed bench for the prefetch unit with a fixed-latency
//          instruction memory model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] grants[$];
  logic [31:0] pops[$];
  int          cyc = 0;
  int          lat = 1;
  int          errors = 0;
  int          checks = 0;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;
  vec_t        tbl [8];

  // Memory contents: an address-dependent pattern so misrouted words show up
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive inputs at negedge, sample outputs 1ns later
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic r);
    mreq_t head;
    @(negedge clk);
    rst            = r;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (r) begin
      mq.delete();
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      head        = mq.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(head.addr);
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    if (!r && imem_req && imem_gnt) begin
      mq.push_back('{addr: imem_addr, due: cyc + lat});
      grants.push_back(imem_addr);
    end
    if (!r && instr_valid && instr_ready && !redir) begin
      pops.push_back(instr_pc);
      check("pop_word", instr, mem_word(instr_pc));
    end
    cyc++;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input int l);
    lat = l;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    grants.delete();
    pops.delete();
  endtask

  // Consumed PCs must form one contiguous stream starting at base
  task automatic check_stream(input string name, input logic [31:0] base, input int min_n);
    logic [31:0] e;
    check({name, "_len_ok"}, 32'(pops.size() >= min_n), 32'h1);
    e = base;
    foreach (pops[i]) begin
      check(name, pops[i], e);
      e = e + 32'd4;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Startup with 1-cycle memory and decode always ready
    tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    tbl[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[6] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[7] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};

    // Reset state
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_req",   32'(s_req),   32'h0);
    check("rst_valid", 32'(s_valid), 32'h0);
    check("rst_addr",  s_addr,       32'h0);
    do_reset(1);

    // Test 1: streaming startup from the table
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rdy, 1'b0, 32'h0, 1'b0);
      check("t1_req",   32'(s_req),   32'(tbl[i].exp_req));
      check("t1_addr",  s_addr,       tbl[i].exp_addr);
      check("t1_valid", 32'(s_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check("t1_pc", s_pc, tbl[i].exp_pc);
    end

    // Test 2: decode stalled -> exactly DEPTH grants, then drain in order
    do_reset(1);
    run(12, 1'b0);
    check("t2_grants_n", grants.size(), 32'd4);
    foreach (grants[i]) check("t2_grant_addr", grants[i], 32'(4 * i));
    check("t2_req_low",  32'(s_req),   32'h0);
    check("t2_hold_vld", 32'(s_valid), 32'h1);
    check("t2_hold_pc",  s_pc,         32'h0);
    grants.delete();
    pops.delete();
    run(8, 1'b1);
    check("t2_resume_n", 32'(grants.size() >= 1), 32'h1);
    if (grants.size() >= 1) check("t2_resume_addr", grants[0], 32'h10);
    check_stream("t2_drain", 32'h0, 5);

    // Test 3: 3-cycle memory, redirect with 3 words in flight and 1 buffered
    do_reset(3);
    run(5, 1'b1);
    step(1'b1, 1'b1, 32'h103, 1'b0);
    check("t3_buf_before", 32'(s_valid), 32'h1);
    check("t3_req_redir",  32'(s_req),   32'h0);
    pops.delete();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t3_flushed",    32'(s_valid), 32'h0);
    check("t3_new_addr",   s_addr,       32'h100);
    run(14, 1'b1);
    check_stream("t3_stream", 32'h100, 3);

    // Test 4: redirect coincident with a response and an offered grant
    do_reset(1);
    run(6, 1'b1);
    step(1'b1, 1'b1, 32'h200, 1'b0);
    check("t4_req_redir", 32'(s_req), 32'h0);
    pops.delete();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t4_vld_r1",  32'(s_valid), 32'h0);
    check("t4_addr_r1", s_addr,       32'h200);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t4_vld_r2",  32'(s_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t4_vld_r3",  32'(s_valid), 32'h1);
    check("t4_pc_r3",   s_pc,         32'h200);
    run(4, 1'b1);
    check_stream("t4_stream", 32'h200, 4);

    // Test 4b: second redirect while stale words are still being dropped
    do_reset(3);
    run(5, 1'b1);
    step(1'b1, 1'b1, 32'h300, 1'b0);
    step(1'b1, 1'b0, 32'h0,   1'b0);
    step(1'b1, 1'b1, 32'h400, 1'b0);
    pops.delete();
    run(14, 1'b1);
    check_stream("t4b_stream", 32'h400, 3);

    // Test 5: fetch address wraps past the top of memory
    do_reset(1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    grants.delete();
    pops.delete();
    run(8, 1'b1);
    check("t5_grants_n", 32'(grants.size() >= 2), 32'h1);
    if (grants.size() >= 2) begin
      check("t5_top",  grants[0], 32'hFFFF_FFFC);
      check("t5_wrap", grants[1], 32'h0000_0000);
    end
    check_stream("t5_stream", 32'hFFFF_FFFC, 3);

    // Test 6: reset with a full buffer
    do_reset(1);
    run(12, 1'b0);
    check("t6_full_vld", 32'(s_valid), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("t6_rst_req",  32'(s_req),   32'h0);
    check("t6_rst_vld",  32'(s_valid), 32'h0);
    check("t6_rst_addr", s_addr,       32'h0);
    grants.delete();
    pops.delete();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_post_vld", 32'(s_valid), 32'h0);
    check("t6_post_req", 32'(s_req),   32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_req_on",   32'(s_req),   32'h1);
    check("t6_req_addr", s_addr,       32'h0);
    run(6, 1'b1);
    check_stream("t6_stream", 32'h0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
